demux5_8_reg: RTL and testbench
===============================

Name: demux5_8_reg

Overview:
Registered 1-to-5 byte distributor, the write-side counterpart of the 5:1 byte mux. Accepts a byte stream under a valid/ready handshake and steers each byte into one of five holding registers (lanes 0-4). Signals when all five lanes hold fresh data, then holds the frame until it is acknowledged. Sits upstream of the mux5_8 read path; its Dout0..Dout4 feed the mux's Din0..Din4.

Parameters:
WIDTH, 8, data width of Din and of each Dout lane
LANES, 5, number of output lanes (fixed at 5; no other value is supported)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Din  input  WIDTH  incoming byte
Din_valid  input  1  Din is valid this cycle
Din_ready  output  1  block accepts Din this cycle
select  input  3  destination lane: 0-3 map to lanes 0-3; 4-7 map to lane 4
Clear  input  1  synchronous flush of all lanes
Frame_ack  input  1  consumer has taken the completed frame
Dout0..Dout4  output  WIDTH each  lane holding registers
Lane_valid  output  5  bit i = lane i written since last clear/ack
Frame_done  output  1  one-cycle pulse when the frame completes
Overwrite  output  1  one-cycle pulse when a write hits an already-valid lane

Behaviour:
- Clocking and reset: one clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset (Reset_n=0, asynchronous): Dout0..4=0, Lane_valid=0, Frame_done=0, Overwrite=0, state=IDLE. Din_ready=1 once reset deasserts.
- States:
  - IDLE: Lane_valid=0.
  - FILL: 1 to 4 lanes valid.
  - HOLD: all 5 lanes valid.
- Din_ready is 1 in IDLE and FILL, 0 in HOLD. It is combinational from state only, not from Din_valid.
- Write: when Din_valid && Din_ready && !Clear at an edge:
  - Dout[lane] <= Din and Lane_valid[lane] <= 1.
  - The new value is visible on the next cycle (latency 1).
  - Bytes offered while Din_ready=0 are neither consumed nor stored.
- Transitions:
  - IDLE -> FILL on the first write.
  - FILL -> HOLD on the write that makes Lane_valid=5'b11111.
  - Frame_done pulses for exactly the first HOLD cycle.
  - HOLD -> IDLE on Frame_ack; Lane_valid is cleared, but Dout contents are retained.
- Overwrite: a write to a lane whose Lane_valid bit is already 1 replaces the data and pulses Overwrite for 1 cycle. Lane_valid and state are unchanged.
- Clear: synchronous. Sets Lane_valid=0 and Dout0..4=0, and goes to IDLE from any state. Clear has priority over a simultaneous write and over Frame_ack.
- Frame_ack outside HOLD is ignored.
- Frame_done and Overwrite are never asserted in the same cycle as Clear.
- select values 5, 6 and 7 behave exactly as 4: lane 4, with no error flag.
- Reset asserted mid-frame: immediate return to reset values; no Frame_done is emitted.

Optional Feature:
Macro DEMUX5_AUTOINC_EN.
- Defined:
  - select is ignored; an internal 3-bit pointer chooses the lane.
  - Pointer resets to 0; increments on each accepted write (0,1,2,3,4, then wraps to 0).
  - Pointer returns to 0 on Reset_n, Clear and Frame_ack-in-HOLD.
  - Overwrite never fires in auto-increment mode because each lane is written once per frame.
- Not defined: lane is taken from select as described above; no pointer logic is synthesized.

Test Plan:
1. Reset: Reset_n=0 mid-cycle -> all Dout=0x00, Lane_valid=0, Din_ready=1 after release, with no clock edge needed.
2. Fill: write 0x11,0x22,0x33,0x44,0x55 with select=0..4 -> Dout0..4=11..55. Lane_valid steps 00001 -> 11111. Frame_done pulses 1 cycle after the 5th write. Din_ready=0.
3. Hold/ack: in HOLD, present Din=0xAA with Din_valid=1 -> no change. Frame_ack=1 -> IDLE, Lane_valid=0, Dout unchanged (11..55), Din_ready=1.
4. Alias/overwrite: write 0x66 sel=7, then 0x77 sel=4 -> Dout4=0x77, Overwrite pulses on the second write, Lane_valid=10000.
5. Clear priority: Clear=1 together with a write of 0x99 to sel=2 -> Dout2=0x00, Lane_valid=0, state IDLE, no Overwrite/Frame_done.
6. DEMUX5_AUTOINC_EN: write 0xA0..0xA4 with select held at 3 -> Dout0..4=A0..A4, Frame_done pulses. After Frame_ack, the next byte 0xB0 lands in Dout0.

Source files
------------

// File: rtl/demux5_8_reg.sv
// Registered 1-to-5 byte distributor. It steers a valid/ready byte stream into five lane registers and holds each completed frame until the consumer acknowledges it.
// Optional DEMUX5_AUTOINC_EN: an internal round-robin pointer picks the lane and select is ignored.
module demux5_8_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic [2:0]       select,
  input  logic             Clear,
  input  logic             Frame_ack,
  output logic [WIDTH-1:0] Dout0,
  output logic [WIDTH-1:0] Dout1,
  output logic [WIDTH-1:0] Dout2,
  output logic [WIDTH-1:0] Dout3,
  output logic [WIDTH-1:0] Dout4,
  output logic [LANES-1:0] Lane_valid,
  output logic             Frame_done,
  output logic             Overwrite
);

  localparam int unsigned LANE_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LANES-1:0]   r_lane_valid;
  logic [LANES-1:0]   w_lane_valid_nxt;
  logic               r_frame_done;
  logic               w_frame_done_nxt;
  logic               r_overwrite;
  logic               w_overwrite_nxt;
  logic [WIDTH-1:0]   r_dout [LANES];
  logic [LANE_W-1:0]  w_lane;
  logic               w_ready;
  logic               w_wr;
  logic               w_hit;

  // Ready depends only on the state, so a held frame can never be disturbed.
  assign w_ready = (r_state != S_HOLD);
  assign w_wr    = Din_valid && w_ready && !Clear;
  assign w_hit   = r_lane_valid[w_lane];

`ifdef DEMUX5_AUTOINC_EN
  logic [LANE_W-1:0] r_ptr;
  logic [LANE_W-1:0] w_ptr_nxt;
  logic              w_unused_select;

  assign w_unused_select = ^select;
  assign w_lane          = r_ptr;

  // Round-robin lane pointer; it restarts whenever a frame is flushed or acknowledged.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (Clear) begin
      w_ptr_nxt = '0;
    end else if ((r_state == S_HOLD) && Frame_ack) begin
      w_ptr_nxt = '0;
    end else if (w_wr) begin
      w_ptr_nxt = (r_ptr == LANE_W'(LANES - 1)) ? '0 : r_ptr + LANE_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  // Select codes 4..7 all alias onto lane 4.
  assign w_lane = select[2] ? LANE_W'(4) : {1'b0, select[1:0]};
`endif

  // Next-state and output-pulse logic
  always_comb begin
    w_state_nxt      = r_state;
    w_lane_valid_nxt = r_lane_valid;
    w_frame_done_nxt = 1'b0;
    w_overwrite_nxt  = 1'b0;
    if (Clear) begin
      w_state_nxt      = S_IDLE;
      w_lane_valid_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            w_lane_valid_nxt[w_lane] = 1'b1;
            w_state_nxt              = S_FILL;
          end
        end
        S_FILL: begin
          if (w_wr) begin
            if (w_hit) begin
              w_overwrite_nxt = 1'b1;
            end else begin
              w_lane_valid_nxt[w_lane] = 1'b1;
              if (w_lane_valid_nxt == {LANES{1'b1}}) begin
                w_state_nxt      = S_HOLD;
                w_frame_done_nxt = 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (Frame_ack) begin
            w_state_nxt      = S_IDLE;
            w_lane_valid_nxt = '0;
          end
        end
        default: begin
          w_state_nxt      = S_IDLE;
          w_lane_valid_nxt = '0;
        end
      endcase
    end
  end

  // Control state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_lane_valid <= '0;
      r_frame_done <= 1'b0;
      r_overwrite  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane_valid <= w_lane_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overwrite  <= w_overwrite_nxt;
    end
  end

  // Lane data: zeroed by Clear, retained across Frame_ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_dout[i] <= '0;
      end
    end else if (Clear) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_dout[i] <= '0;
      end
    end else if (w_wr) begin
      r_dout[w_lane] <= Din;
    end
  end

  assign Din_ready  = w_ready;
  assign Dout0      = r_dout[0];
  assign Dout1      = r_dout[1];
  assign Dout2      = r_dout[2];
  assign Dout3      = r_dout[3];
  assign Dout4      = r_dout[4];
  assign Lane_valid = r_lane_valid;
  assign Frame_done = r_frame_done;
  assign Overwrite  = r_overwrite;

endmodule

// File: tb/tb_demux5_8_reg.sv
// Self-checking bench for demux5_8_reg: directed frame scenarios plus randomized traffic, compared every cycle against a lane-array reference model.
module tb_demux5_8_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [2:0] sel;
  logic       clr;
  logic       ack;
  logic [7:0] d0, d1, d2, d3, d4;
  logic [4:0] lane_valid;
  logic       frame_done;
  logic       overwrite;
  logic [7:0] dv [5];

  int total = 0;
  int bad   = 0;

  // Reference model: plain lane arrays; "holding" simply means every lane is valid.
  logic [7:0] m_dout [5];
  logic [4:0] m_valid;
  logic       m_done;
  logic       m_ovw;
  int         m_ptr;

  always #5 clk = ~clk;

  assign dv[0] = d0;
  assign dv[1] = d1;
  assign dv[2] = d2;
  assign dv[3] = d3;
  assign dv[4] = d4;

  demux5_8_reg dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .Din        (din),
    .Din_valid  (din_valid),
    .Din_ready  (din_ready),
    .select     (sel),
    .Clear      (clr),
    .Frame_ack  (ack),
    .Dout0      (d0),
    .Dout1      (d1),
    .Dout2      (d2),
    .Dout3      (d3),
    .Dout4      (d4),
    .Lane_valid (lane_valid),
    .Frame_done (frame_done),
    .Overwrite  (overwrite)
  );

  always @(posedge clk or negedge rst_n) begin
    int  lane;
    logic full;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_dout[i] = 8'h00;
      m_valid = 5'b0;
      m_done  = 1'b0;
      m_ovw   = 1'b0;
      m_ptr   = 0;
    end else begin
      full   = (m_valid == 5'b11111);
      m_done = 1'b0;
      m_ovw  = 1'b0;
      if (clr) begin
        for (int i = 0; i < 5; i++) m_dout[i] = 8'h00;
        m_valid = 5'b0;
        m_ptr   = 0;
      end else if (full) begin
        if (ack) begin
          m_valid = 5'b0;
          m_ptr   = 0;
        end
      end else if (din_valid) begin
`ifdef DEMUX5_AUTOINC_EN
        lane = m_ptr;
`else
        lane = (int'(sel) > 4) ? 4 : int'(sel);
`endif
        if (m_valid[lane]) m_ovw = 1'b1;
        m_dout[lane]  = din;
        m_valid[lane] = 1'b1;
        m_ptr         = (m_ptr + 1) % 5;
        if (m_valid == 5'b11111) m_done = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) chk($sformatf("dout%0d", i), 32'(dv[i]), 32'(m_dout[i]));
    chk("lane_valid", 32'(lane_valid), 32'(m_valid));
    chk("din_ready", 32'(din_ready), 32'(m_valid != 5'b11111));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("overwrite", 32'(overwrite), 32'(m_ovw));
  endtask

  // Drive at a falling edge, let one rising edge pass, then check at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic c, input logic a);
    din_valid = v;
    din       = d;
    sel       = s;
    clr       = c;
    ack       = a;
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("%s_dout%0d", tag, i), 32'(dv[i]), 32'h0);
    chk({tag, "_lane_valid"}, 32'(lane_valid), 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, "_din_ready"}, 32'(din_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    sel       = 3'd0;
    clr       = 1'b0;
    ack       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
    chk("rst_lane_valid", 32'(lane_valid), 32'h0);
    chk("rst_din_ready", 32'(din_ready), 32'h1);

    // Fill one frame with select 0..4
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h11 * (i + 1)), 3'(i), 1'b0, 1'b0);
      chk($sformatf("fill_valid%0d", i), 32'(lane_valid), 32'((1 << (i + 1)) - 1));
    end
    chk("fill_done", 32'(frame_done), 32'h1);
    chk("fill_ready", 32'(din_ready), 32'h0);
    chk("fill_dout4", 32'(d4), 32'h55);

    // Hold ignores input, then acknowledge
    step(1'b1, 8'hAA, 3'd0, 1'b0, 1'b0);
    chk("hold_done_once", 32'(frame_done), 32'h0);
    chk("hold_dout0", 32'(d0), 32'h11);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("ack_valid", 32'(lane_valid), 32'h0);
    chk("ack_ready", 32'(din_ready), 32'h1);
    chk("ack_dout2", 32'(d2), 32'h33);

`ifndef DEMUX5_AUTOINC_EN
    // Select alias and overwrite
    step(1'b1, 8'h66, 3'd7, 1'b0, 1'b0);
    chk("alias_dout4", 32'(d4), 32'h66);
    chk("alias_ovw", 32'(overwrite), 32'h0);
    step(1'b1, 8'h77, 3'd4, 1'b0, 1'b0);
    chk("ovw_pulse", 32'(overwrite), 32'h1);
    chk("ovw_dout4", 32'(d4), 32'h77);
    chk("ovw_valid", 32'(lane_valid), 32'h10);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("ovw_one_cycle", 32'(overwrite), 32'h0);
`else
    // Pointer ignores select and wraps per frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 3'd3, 1'b0, 1'b0);
    chk("ai_done", 32'(frame_done), 32'h1);
    chk("ai_dout0", 32'(d0), 32'hA0);
    chk("ai_dout4", 32'(d4), 32'hA4);
    step(1'b0, 8'h00, 3'd3, 1'b0, 1'b1);
    step(1'b1, 8'hB0, 3'd3, 1'b0, 1'b0);
    chk("ai_wrap", 32'(d0), 32'hB0);
    chk("ai_valid", 32'(lane_valid), 32'h01);
`endif

    // Clear wins over a simultaneous write
    step(1'b1, 8'h99, 3'd2, 1'b1, 1'b0);
    chk("clr_dout2", 32'(d2), 32'h0);
    chk("clr_dout4", 32'(d4), 32'h0);
    chk("clr_valid", 32'(lane_valid), 32'h0);
    chk("clr_ovw", 32'(overwrite), 32'h0);
    chk("clr_done", 32'(frame_done), 32'h0);

    // Reset in the middle of a frame
    step(1'b1, 8'h12, 3'd1, 1'b0, 1'b0);
    step(1'b1, 8'h34, 3'd3, 1'b0, 1'b0);
    async_reset_check("midrst");

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(299) == 0) begin
        async_reset_check("rndrst");
      end else begin
        step(1'($urandom_range(9) < 7), 8'($urandom), 3'($urandom_range(7)),
             1'($urandom_range(39) == 0), 1'($urandom_range(3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
